// File: rtl/div_float_if.sv
// Handshake and operand/result bundle for the sequential float divider.
// The master issues a/b with start; the slave answers with busy/done and the held result.
interface div_float_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] m;
  logic        div_by_zero;

  // Handshake: a/b are taken on the rising edge where start=1 and busy=0.
  // done pulses for one cycle; m/div_by_zero then hold until the next accepted start.
  modport master (output start, a, b, input busy, done, m, div_by_zero);
  modport slave  (input start, a, b, output busy, done, m, div_by_zero);
endinterface

// File: rtl/div_float.sv
// Sequential single-precision divider m = a / b: restoring mantissa division, one quotient
// bit per clock, truncating, exponent arithmetic wraps mod 256.
module div_float #(
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst,
  div_float_if.slave  bus,
  output logic [1:0]  dbg_state
);
  localparam logic [7:0] BIAS8 = 8'(EXP_BIAS);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, NORM = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [24:0] r_q;
  logic [23:0] d_q;
  logic [24:0] q_q;
  logic [7:0]  ed_q;
  logic        sign_q, zero_a_q, zero_b_q;
  logic        done_q, dbz_q;
  logic [31:0] m_q;

  logic        r_ge;
  logic [24:0] r_sub;
  logic [24:0] r_next;
  logic [22:0] mant;
  logic [7:0]  expn;

  // Remainder stays below 2*D, so both the subtracted and plain shifts fit in 25 bits.
  always_comb begin
    r_ge   = (r_q >= {1'b0, d_q});
    r_sub  = r_q - {1'b0, d_q};
    r_next = r_ge ? {r_sub[23:0], 1'b0} : {r_q[23:0], 1'b0};
    mant   = q_q[24] ? q_q[23:1] : q_q[22:0];
    expn   = q_q[24] ? ed_q : (ed_q - 8'd1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = DIV;
      DIV:     if (cnt_q == 5'd24) state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      r_q      <= 25'd0;
      d_q      <= 24'd0;
      q_q      <= 25'd0;
      ed_q     <= 8'd0;
      sign_q   <= 1'b0;
      zero_a_q <= 1'b0;
      zero_b_q <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      m_q      <= 32'd0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sign_q   <= bus.a[31] ^ bus.b[31];
            zero_a_q <= (bus.a == 32'd0);
            zero_b_q <= (bus.b == 32'd0);
            d_q      <= {1'b1, bus.b[22:0]};
            r_q      <= {2'b01, bus.a[22:0]};
            ed_q     <= bus.a[30:23] - bus.b[30:23] + BIAS8;
            cnt_q    <= 5'd0;
          end
        end
        DIV: begin
          r_q   <= r_next;
          q_q   <= {q_q[23:0], r_ge};
          cnt_q <= cnt_q + 5'd1;
        end
        NORM: begin
          done_q <= 1'b1;
          // Divide-by-zero wins over a zero dividend, so 0/0 reports div_by_zero.
          if (zero_b_q) begin
            m_q   <= {sign_q, 8'hFF, 23'd0};
            dbz_q <= 1'b1;
          end else if (zero_a_q) begin
            m_q   <= 32'd0;
            dbz_q <= 1'b0;
          end else begin
            m_q   <= {sign_q, expn, mant};
            dbz_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.m           = m_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_div_float.sv
// Scoreboard bench for div_float: directed vectors with hand-computed results, a short
// model-checked sweep, handshake/latency, ignored-start and mid-operation reset cases.
module tb_div_float;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  div_float_if bus ();

  div_float #(.EXP_BIAS(127)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  logic        exp_z_q[$];
  int          exp_t_q[$];
  int          last_done = -1;
  int          prev_done = -1;
  logic        prev_done_lvl = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(posedge clk) begin
    #1;
    if (bus.done) begin
      check("done_single_cycle", {31'd0, prev_done_lvl}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("m", bus.m, exp_q.pop_front());
        check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, exp_z_q.pop_front()});
        check("latency", 32'(cyc - exp_t_q.pop_front()), 32'd26);
      end
      prev_done = last_done;
      last_done = cyc;
    end
    prev_done_lvl = bus.done;
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, output int t);
    int n = 0;
    while (bus.busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    t = cyc;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] em, input logic ez);
    int t;
    drive(a, b, t);
    exp_q.push_back(em);
    exp_z_q.push_back(ez);
    exp_t_q.push_back(t);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #2;
  endtask

  // Truncating reference: long-division quotient of the full mantissas.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] num, q;
    logic [7:0]  ed;
    if (b == 32'd0) return {a[31] ^ b[31], 8'hFF, 23'd0};
    if (a == 32'd0) return 32'd0;
    num = {1'b1, a[22:0], 24'd0};
    q   = num / {24'd0, 1'b1, b[22:0]};
    ed  = a[30:23] - b[30:23] + 8'd127;
    if (q[24]) return {a[31] ^ b[31], ed, q[23:1]};
    return {a[31] ^ b[31], ed - 8'd1, q[22:0]};
  endfunction

  initial begin
    int t;
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.a = 32'd0; bus.b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_m", bus.m, 32'd0);
    check("reset_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // 6.0 / 2.0 with busy held through the whole operation
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    begin
      int bad = 0;
      if (!bus.busy) bad++;
      for (int i = 0; i < 25; i++) begin
        @(posedge clk); #1;
        if (!bus.busy) bad++;
      end
      check("busy_throughout", 32'(bad), 32'd0);
      @(posedge clk); #1;
      check("busy_drops_with_done", {30'd0, bus.busy, bus.done}, 32'd1);
    end
    drain();

    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);
    issue(32'hC1000000, 32'h3F000000, 32'hC1800000, 1'b0);
    issue(32'h00000000, 32'h40A00000, 32'h00000000, 1'b0);
    issue(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1);
    issue(32'h00000000, 32'h00000000, 32'h7F800000, 1'b1);
    drain();

    // start during DIV is ignored
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.a = 32'h3F800000; bus.b = 32'h40400000; bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    // start in the done cycle is accepted
    begin
      int n = 0;
      while (!bus.done && n < 40) begin
        @(posedge clk); #1; n++;
      end
      check("wait_done", {31'd0, bus.done}, 32'd1);
    end
    issue(32'h41200000, 32'h40A00000, 32'h40000000, 1'b0);
    drain();
    check("back_to_back_gap", 32'(last_done - prev_done), 32'd27);

    // reset mid-operation aborts with no done
    drive(32'h40C00000, 32'h40000000, t);
    repeat (12) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_m", bus.m, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk) rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk); #1;
        if (bus.done) seen++;
      end
      check("no_done_after_abort", 32'(seen), 32'd0);
    end
    issue(32'h41000000, 32'h40800000, 32'h40000000, 1'b0);
    drain();

    // normal-exponent sweep against the reference quotient
    for (int i = 0; i < 8; i++) begin
      ra = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
      issue(ra, rb, ref_div(ra, rb), 1'b0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
